// File: rtl/wb_regfile.sv
// Writeback stage: selects the final result and writes it into the register file.
// Also provides the two decode read ports and the retired-instruction counter.
// Define WB_RF_BYPASS_EN to make the read ports write-through (W-stage value visible in the same cycle).
module wb_regfile #(
  parameter int XLEN  = 32,
  parameter int NREG  = 32,
  parameter int CNT_W = 64
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             RegWriteW,
  input  logic [1:0]       ResultSrcW,
  input  logic             ValidW,
  input  logic [4:0]       RdW,
  input  logic [XLEN-1:0]  ALUResultW,
  input  logic [XLEN-1:0]  ReadDataW,
  input  logic [XLEN-1:0]  PCPlus4W,
  input  logic [4:0]       Rs1D,
  input  logic [4:0]       Rs2D,
  output logic [XLEN-1:0]  RD1D,
  output logic [XLEN-1:0]  RD2D,
  output logic [XLEN-1:0]  ResultW,
  output logic [CNT_W-1:0] InstretW
);

  logic [XLEN-1:0] regs [NREG];
  logic            writeEn;

  always_comb begin
    ResultW = '0;
    case (ResultSrcW)
      2'b00:   ResultW = ALUResultW;
      2'b01:   ResultW = ReadDataW;
      2'b10:   ResultW = PCPlus4W;
      default: ResultW = '0;
    endcase
  end

  // Bubbles and x0 destinations never modify architectural state.
  assign writeEn = RegWriteW & ValidW & (RdW != 5'd0);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
      InstretW <= '0;
    end else begin
      if (writeEn) regs[RdW] <= ResultW;
      if (ValidW) InstretW <= InstretW + CNT_W'(1);
    end
  end

`ifdef WB_RF_BYPASS_EN
  assign RD1D = (Rs1D == 5'd0) ? '0 : (writeEn && (Rs1D == RdW)) ? ResultW : regs[Rs1D];
  assign RD2D = (Rs2D == 5'd0) ? '0 : (writeEn && (Rs2D == RdW)) ? ResultW : regs[Rs2D];
`else
  // Without bypass the decode stage sees the old value until the edge; hazard unit must cover it.
  assign RD1D = (Rs1D == 5'd0) ? '0 : regs[Rs1D];
  assign RD2D = (Rs2D == 5'd0) ? '0 : regs[Rs2D];
`endif

endmodule
